// File: rtl/fizzbuzz_pkg.sv
// -----------------------------------------------------------------------------
// fizzbuzz_pkg
// Shared types for the FizzBuzz stream controller:
//   fb_kind_e   token classification carried on out_kind ({buzz, fizz} bits)
//   fb_state_e  controller state
//   cnt_width() width of a modulo counter for a given divisor (min 1 bit)
// -----------------------------------------------------------------------------
package fizzbuzz_pkg;

   typedef enum logic [1:0] {
      KIND_NUM      = 2'd0,
      KIND_FIZZ     = 2'd1,
      KIND_BUZZ     = 2'd2,
      KIND_FIZZBUZZ = 2'd3
   } fb_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

   // A divisor of 1 still gets a 1-bit counter; it simply never leaves 0.
   function automatic int cnt_width(input int mod);
      return (mod > 1) ? $clog2(mod) : 1;
   endfunction

endpackage : fizzbuzz_pkg

// File: rtl/fizzbuzz_mod_counter.sv
// -----------------------------------------------------------------------------
// fizzbuzz_mod_counter
// Incremental modulo-MOD counter replacing a per-value % operation.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   clr          synchronous clear to 0 (wins over inc)
//   inc          advance by one, wrapping from MOD-1 to 0
//   cnt          current residue
//   is_zero      residue is 0, i.e. the tracked value is divisible by MOD
// -----------------------------------------------------------------------------
module fizzbuzz_mod_counter
   import fizzbuzz_pkg::*;
#(
   parameter int MOD = 3
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clr,
   input  logic                      inc,
   output logic [cnt_width(MOD)-1:0] cnt,
   output logic                      is_zero
);

   localparam int CNT_W = cnt_width(MOD);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With MOD == 1 the wrap compare is against 0, so the counter stays 0.
   always_comb begin
      // NOTE: assign the default first so every path drives cnt_d; a missing
      // branch would otherwise infer a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = (cnt_q == CNT_W'(MOD - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign is_zero = (cnt_q == '0);

endmodule : fizzbuzz_mod_counter

// File: rtl/fizzbuzz_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fizzbuzz_stream_ctrl
// Runs one FizzBuzz count (values 0..len_eff-1) per accepted start and emits a
// classified token per value on a valid/ready stream, with abort support.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   start, len    run request (IDLE only); len 0 or >MAX_CYCLES means MAX_CYCLES
//   abort         stop the current run, no done pulse
//   out_valid     token present (only in RUN)
//   out_ready     consumer accepts the token
//   out_value     current count value
//   out_kind      0 NUM, 1 FIZZ, 2 BUZZ, 3 FIZZBUZZ
//   out_last      token is the final value of the run
//   busy          controller not idle
//   done          one-cycle pulse after the last token is accepted
// -----------------------------------------------------------------------------
module fizzbuzz_stream_ctrl
   import fizzbuzz_pkg::*;
#(
   parameter int FIZZ       = 3,
   parameter int BUZZ       = 5,
   parameter int MAX_CYCLES = 100
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 start,
   input  logic [$clog2(MAX_CYCLES+1)-1:0]      len,
   input  logic                                 abort,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(MAX_CYCLES+1)-1:0]      out_value,
   output logic [1:0]                           out_kind,
   output logic                                 out_last,
   output logic                                 busy,
   output logic                                 done
);

   localparam int CW = $clog2(MAX_CYCLES + 1);

   fb_state_e        state_q, state_d;
   logic [CW-1:0]    value_q, value_d;
   logic [CW-1:0]    len_q,   len_d;
   logic [CW-1:0]    len_eff;
   logic             cnt_clr, cnt_inc;
   logic             handshake;
   logic             is_last;
   logic             fizz_is_zero, buzz_is_zero;
   logic [cnt_width(FIZZ)-1:0] fizz_cnt;
   logic [cnt_width(BUZZ)-1:0] buzz_cnt;
   fb_kind_e         kind;

   // Out-of-range requests fall back to a full-length run.
   assign len_eff = ((len == '0) || (len > CW'(MAX_CYCLES))) ? CW'(MAX_CYCLES) : len;

   assign handshake = out_valid && out_ready;
   assign is_last   = (value_q == len_q - CW'(1));

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      len_d   = len_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // start wins over a same-cycle abort because abort is not looked at here.
            if (start) begin
               state_d = ST_RUN;
               value_d = '0;
               len_d   = len_eff;
               cnt_clr = 1'b1;
            end
         end
         ST_RUN: begin
            // Abort takes priority: a coincident handshake does not advance the count.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (handshake) begin
               if (is_last) begin
                  state_d = ST_DONE;
               end else begin
                  value_d = value_q + CW'(1);
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         value_q <= '0;
         len_q   <= CW'(MAX_CYCLES);
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         len_q   <= len_d;
      end
   end

   fizzbuzz_mod_counter #(.MOD(FIZZ)) u_fizz_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .cnt     (fizz_cnt),
      .is_zero (fizz_is_zero)
   );

   fizzbuzz_mod_counter #(.MOD(BUZZ)) u_buzz_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .cnt     (buzz_cnt),
      .is_zero (buzz_is_zero)
   );

   // The residues themselves are only needed to confirm the divisibility flags.
   always_comb begin
      assert (fizz_is_zero == (fizz_cnt == '0));
      assert (buzz_is_zero == (buzz_cnt == '0));
   end

   // Counters sit at 0 after reset and after each start, so kind reads
   // FIZZBUZZ for value 0 without any special case.
   assign kind      = fb_kind_e'({buzz_is_zero, fizz_is_zero});

   assign out_valid = (state_q == ST_RUN);
   assign out_value = value_q;
   assign out_kind  = kind;
   assign out_last  = (state_q == ST_RUN) && is_last;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule : fizzbuzz_stream_ctrl

// File: tb/tb_fizzbuzz_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_stream_ctrl
// Two controller instances: defaults (3/5/100) and a small one (1/4/8).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fizzbuzz_stream_ctrl;

   logic clk;
   logic resetn;

   // Instance A: FIZZ=3, BUZZ=5, MAX_CYCLES=100 (CW=7)
   logic       start_a, abort_a, out_ready_a;
   logic [6:0] len_a;
   logic       out_valid_a, out_last_a, busy_a, done_a;
   logic [6:0] out_value_a;
   logic [1:0] out_kind_a;

   // Instance B: FIZZ=1, BUZZ=4, MAX_CYCLES=8 (CW=4)
   logic       start_b, abort_b, out_ready_b;
   logic [3:0] len_b;
   logic       out_valid_b, out_last_b, busy_b, done_b;
   logic [3:0] out_value_b;
   logic [1:0] out_kind_b;

   fizzbuzz_stream_ctrl dut_a (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start_a),
      .len       (len_a),
      .abort     (abort_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .out_value (out_value_a),
      .out_kind  (out_kind_a),
      .out_last  (out_last_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   fizzbuzz_stream_ctrl #(.FIZZ(1), .BUZZ(4), .MAX_CYCLES(8)) dut_b (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start_b),
      .len       (len_b),
      .abort     (abort_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_value (out_value_b),
      .out_kind  (out_kind_b),
      .out_last  (out_last_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] value;
      logic [1:0]  kind;
      logic        last;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct {
      int sel;       // 0 = instance A, 1 = instance B
      int len;       // requested length as driven on len
      bit rnd;       // random 50% out_ready
      bit poke;      // pulse start during RUN and DONE
      bit ab_start;  // abort together with start in IDLE
      int exp_n;     // expected number of tokens
      int exp_kind;  // expected kind of the final token
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   int kinds_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference classification straight from the divisibility rules.
   function automatic int model_kind(input int v, input int f, input int b);
      return ((v % b == 0) ? 2 : 0) + ((v % f == 0) ? 1 : 0);
   endfunction

   function automatic obs_t get_obs(input int sel);
      obs_t o;
      if (sel == 0) begin
         o.valid = out_valid_a; o.value = 32'(out_value_a); o.kind = out_kind_a;
         o.last  = out_last_a;  o.busy  = busy_a;           o.done = done_a;
      end else begin
         o.valid = out_valid_b; o.value = 32'(out_value_b); o.kind = out_kind_b;
         o.last  = out_last_b;  o.busy  = busy_b;           o.done = done_b;
      end
      return o;
   endfunction

   task automatic drive(input int sel, input bit st, input int l, input bit ab, input bit rdy);
      if (sel == 0) begin
         start_a = st; len_a = 7'(l); abort_a = ab; out_ready_a = rdy;
      end else begin
         start_b = st; len_b = 4'(l); abort_b = ab; out_ready_b = rdy;
      end
   endtask

   task automatic check_reset(input int sel);
      obs_t o;
      o = get_obs(sel);
      check("rst_valid", 32'(o.valid), 0);
      check("rst_value", o.value, 0);
      check("rst_kind",  32'(o.kind), 3);
      check("rst_last",  32'(o.last), 0);
      check("rst_busy",  32'(o.busy), 0);
      check("rst_done",  32'(o.done), 0);
   endtask

   // One complete run, every presented token compared with the model each cycle
   // (so a stalled token must also stay unchanged).
   task automatic run(input int sel, input int l, input bit rnd, input bit poke,
                      input bit ab_start, input int exp_n, input int exp_kind);
      obs_t o;
      int   idx       = 0;
      int   last_kind = -1;
      bit   fin       = 1'b0;
      bit   hs;
      int   f = (sel == 0) ? 3 : 1;
      int   b = (sel == 0) ? 5 : 4;
      kinds_q.delete();
      drive(sel, 1'b1, l, ab_start, 1'b0);
      @(negedge clk);
      drive(sel, 1'b0, l, 1'b0, 1'b0);
      o = get_obs(sel);
      check("start_busy", 32'(o.busy), 1);
      for (int cyc = 0; cyc < 1000; cyc++) begin
         o = get_obs(sel);
         if (!o.valid) break;
         check("tok_value", o.value, 32'(idx));
         check("tok_kind",  32'(o.kind), 32'(model_kind(idx, f, b)));
         check("tok_last",  32'(o.last), 32'(idx == exp_n - 1));
         hs = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         // A start with len=1 mid-run must be ignored, otherwise the run shortens.
         drive(sel, poke && (idx == 2), poke ? 1 : l, 1'b0, hs);
         @(negedge clk);
         if (hs) begin
            kinds_q.push_back(int'(o.kind));
            last_kind = int'(o.kind);
            idx++;
            if (idx == exp_n) begin
               fin = 1'b1;
               break;
            end
         end
      end
      check("token_count", 32'(idx), 32'(exp_n));
      check("final_kind",  32'(last_kind), 32'(exp_kind));
      if (fin) begin
         o = get_obs(sel);
         check("done_valid", 32'(o.valid), 0);
         check("done_pulse", 32'(o.done), 1);
         check("done_busy",  32'(o.busy), 1);
         // start and abort presented in DONE must both be ignored.
         drive(sel, poke, 1, poke, 1'b0);
         @(negedge clk);
         drive(sel, 1'b0, l, 1'b0, 1'b0);
         o = get_obs(sel);
         check("idle_valid", 32'(o.valid), 0);
         check("idle_done",  32'(o.done), 0);
         check("idle_busy",  32'(o.busy), 0);
      end
   endtask

   // Abort on instance A once at_value is presented; with_hs also offers ready.
   task automatic abort_test(input bit with_hs, input int at_value);
      obs_t o;
      drive(0, 1'b1, 15, 1'b0, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 15, 1'b0, 1'b1);
      repeat (at_value) @(negedge clk);
      o = get_obs(0);
      check("abort_pre_value", o.value, 32'(at_value));
      drive(0, 1'b0, 15, 1'b1, with_hs);
      @(negedge clk);
      drive(0, 1'b0, 15, 1'b0, 1'b0);
      o = get_obs(0);
      check("abort_valid", 32'(o.valid), 0);
      check("abort_busy",  32'(o.busy), 0);
      check("abort_done",  32'(o.done), 0);
      @(negedge clk);
      o = get_obs(0);
      check("abort_no_done", 32'(o.done), 0);
   endtask

   // Reset asserted between clock edges while a token is stalled.
   task automatic reset_mid(input int sel);
      drive(sel, 1'b1, 0, 1'b0, 1'b1);
      @(negedge clk);
      drive(sel, 1'b0, 0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      drive(sel, 1'b0, 0, 1'b0, 1'b0);
      #2 resetn = 1'b0;
      #1 check_reset(sel);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [14];
      int   exp15 [15];
      obs_t o;
      exp15 = '{3, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 0};
      vecs = '{
         '{0, 15,  0, 0, 0, 15,  0},
         '{0, 15,  1, 0, 0, 15,  0},
         '{0, 0,   1, 0, 0, 100, 1},
         '{0, 1,   0, 0, 0, 1,   3},
         '{0, 101, 0, 0, 0, 100, 1},
         '{0, 127, 1, 0, 0, 100, 1},
         '{0, 5,   1, 1, 0, 5,   0},
         '{0, 6,   0, 0, 1, 6,   2},
         '{0, 31,  1, 0, 0, 31,  3},
         '{1, 0,   0, 0, 0, 8,   1},
         '{1, 9,   1, 0, 0, 8,   1},
         '{1, 15,  0, 0, 0, 8,   1},
         '{1, 5,   1, 1, 1, 5,   3},
         '{1, 2,   0, 0, 0, 2,   1}
      };

      resetn = 1'b0;
      drive(0, 1'b0, 0, 1'b0, 1'b0);
      drive(1, 1'b0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check_reset(0);
      check_reset(1);
      resetn = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run(vecs[i].sel, vecs[i].len, vecs[i].rnd, vecs[i].poke,
             vecs[i].ab_start, vecs[i].exp_n, vecs[i].exp_kind);
         if (i == 0) begin
            check("len15_kinds_size", 32'(kinds_q.size()), 15);
            for (int k = 0; k < kinds_q.size() && k < 15; k++)
               check("len15_kind_seq", 32'(kinds_q[k]), 32'(exp15[k]));
         end
      end

      abort_test(1'b0, 8);
      abort_test(1'b1, 3);

      // Abort while idle has no effect.
      drive(0, 1'b0, 15, 1'b1, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 15, 1'b0, 1'b0);
      o = get_obs(0);
      check("idle_abort_busy",  32'(o.busy), 0);
      check("idle_abort_valid", 32'(o.valid), 0);

      run(0, 15, 1'b0, 1'b0, 1'b0, 15, 0);

      reset_mid(0);
      run(0, 0, 1'b1, 1'b0, 1'b0, 100, 1);
      reset_mid(1);
      run(1, 0, 1'b1, 1'b0, 1'b0, 8, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fizzbuzz_stream_ctrl
